// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data memory between the CPU MEM stage and a DMA/loader port.
// Optional build macro DMEM_ARB_ALIGN_CHK_EN suppresses misaligned accesses and flags a sticky err_o.
module dmem_arbiter #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 32,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_rvalid_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    typedef enum logic {S_CPU, S_FORCE} state_t;

    localparam logic [3:0] BURST = 4'(MAX_CPU_BURST);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_cnt_nxt, cnt_inc;
    logic              cpu_gnt, dma_gnt, any_gnt, acc_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              vld_p1;
    logic [DATA_W-1:0] dma_rdata_p1;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr_i[31:ADDR_W];
    assign cnt_inc        = starve_cnt + 4'd1;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        cpu_gnt        = 1'b0;
        dma_gnt        = 1'b0;
        case (state)
            S_CPU: begin
                if (cpu_req_i) begin
                    cpu_gnt = 1'b1;
                    // Only contended CPU grants count toward starvation; an uncontended one breaks the streak
                    if (dma_req_i) begin
                        starve_cnt_nxt = cnt_inc;
                        if (cnt_inc == BURST) state_nxt = S_FORCE;
                    end else begin
                        starve_cnt_nxt = 4'd0;
                    end
                end else if (dma_req_i) begin
                    dma_gnt        = 1'b1;
                    starve_cnt_nxt = 4'd0;
                end
            end
            S_FORCE: begin
                starve_cnt_nxt = 4'd0;
                state_nxt      = S_CPU;
                if (dma_req_i) dma_gnt = 1'b1;
                else           cpu_gnt = cpu_req_i;
            end
            default: begin
                state_nxt      = S_CPU;
                starve_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign any_gnt   = cpu_gnt | dma_gnt;
    assign sel_addr  = dma_gnt ? dma_addr_i  : cpu_addr_i[ADDR_W-1:0];
    assign sel_we    = dma_gnt ? dma_we_i    : cpu_we_i;
    assign sel_wdata = dma_gnt ? dma_wdata_i : cpu_wdata_i;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign acc_ok = (sel_addr[1:0] == 2'b00);
`else
    assign acc_ok = 1'b1;
`endif

    assign mem_re_o    = any_gnt & ~sel_we & acc_ok;
    assign mem_we_o    = any_gnt &  sel_we & acc_ok;
    assign mem_addr_o  = any_gnt ? sel_addr  : '0;
    assign mem_wdata_o = any_gnt ? sel_wdata : '0;
    assign cpu_rdata_o = mem_rdata_i;
    assign cpu_stall_o = cpu_req_i & dma_gnt;
    assign dma_gnt_o   = dma_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_CPU;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // stage p1: DMA read data captured on the edge after its grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1       <= 1'b0;
            dma_rdata_p1 <= '0;
        end else begin
            vld_p1 <= dma_gnt & ~dma_we_i & acc_ok;
            if (dma_gnt & ~dma_we_i & acc_ok) dma_rdata_p1 <= mem_rdata_i;
        end
    end

    assign dma_rvalid_o = vld_p1;
    assign dma_rdata_o  = dma_rdata_p1;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  err_q <= 1'b0;
        else if (any_gnt & ~acc_ok) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus hand sequences for reset and alignment.
module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              dma_gnt, dma_rvalid;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              err;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_gnt_o(dma_gnt), .dma_rdata_o(dma_rdata), .dma_rvalid_o(dma_rvalid),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .err_o(err)
    );

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [6:0]  daddr;
        logic [31:0] dwd, mrd;
        logic        xre, xwe;
        logic [6:0]  xaddr;
        logic [31:0] xwd;
        logic        xstall, xgnt, xrv;
        logic [31:0] xrd;
    } vec_t;

    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hold_rd;

    function automatic vec_t mk(input logic creq, cwe, input logic [31:0] caddr, cwd,
                                input logic dreq, dwe, input logic [6:0] daddr, input logic [31:0] dwd, mrd,
                                input logic xre, xwe, input logic [6:0] xaddr, input logic [31:0] xwd,
                                input logic xstall, xgnt, xrv, input logic [31:0] xrd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
        v.xre = xre; v.xwe = xwe; v.xaddr = xaddr; v.xwd = xwd;
        v.xstall = xstall; v.xgnt = xgnt; v.xrv = xrv; v.xrd = xrd;
        return v;
    endfunction

    // Contended cycle won by the CPU (load from 0x08), DMA read of 0x30 waiting
    task automatic add_c(input logic [31:0] mrd);
        tbl.push_back(mk(1, 0, 32'h08, 32'h1111_1111, 1, 0, 7'h30, 32'h2222_2222, mrd,
                         1, 0, 7'h08, 32'h1111_1111, 0, 0, 0, hold_rd));
    endtask

    // Contended cycle where the forced DMA slot is taken and the CPU stalls
    task automatic add_d(input logic [31:0] mrd);
        hold_rd = mrd;
        tbl.push_back(mk(1, 0, 32'h08, 32'h1111_1111, 1, 0, 7'h30, 32'h2222_2222, mrd,
                         1, 0, 7'h30, 32'h2222_2222, 1, 1, 1, mrd));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic creq, cwe, input logic [31:0] caddr, cwd,
                       input logic dreq, dwe, input logic [6:0] daddr, input logic [31:0] dwd, mrd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; mem_rdata = mrd;
    endtask

    task automatic contended();
        drv(1, 0, 32'h08, 32'h1111_1111, 1, 0, 7'h30, 32'h2222_2222, 32'h7777_0000);
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state, and combinational grants during reset follow S_CPU rules
        @(negedge clk);
        drv(0, 0, 0, 0, 1, 1, 7'h44, 32'hABCD_0001, 0);
        #1;
        chk("rst_rvalid", 32'(dma_rvalid), 0);
        chk("rst_rdata", dma_rdata, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dma_gnt", 32'(dma_gnt), 1);
        chk("rst_mem_we", 32'(mem_we), 1);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        hold_rd = 32'h0;
        tbl.push_back(mk(1, 1, 32'h10, 32'h1234, 0, 0, 0, 0, 0,
                         0, 1, 7'h10, 32'h1234, 0, 0, 0, 32'h0));
        hold_rd = 32'hDEAD_BEEF;
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7'h20, 0, 32'hDEAD_BEEF,
                         1, 0, 7'h20, 0, 0, 1, 1, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_5555,
                         0, 0, 7'h00, 0, 0, 0, 0, hold_rd));
        tbl.push_back(mk(1, 0, 32'hFFFF_FF84, 0, 0, 0, 0, 0, 32'hA5A5_A5A5,
                         1, 0, 7'h04, 0, 0, 0, 0, hold_rd));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7'h7C, 32'hCAFE_F00D, 32'h0,
                         0, 1, 7'h7C, 32'hCAFE_F00D, 0, 1, 0, hold_rd));
        // Sustained contention: C,C,C,C,D,C,C,C,C,D
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) add_c(32'h3000_0000 + 32'(k * 16 + j));
            add_d(32'h4000_0000 + 32'(k));
        end
        // Three contended, an uncontended CPU cycle clears the streak, then four more before D
        for (int j = 0; j < 3; j++) add_c(32'h5000_0000 + 32'(j));
        tbl.push_back(mk(1, 0, 32'h08, 32'h1111_1111, 0, 0, 7'h30, 32'h2222_2222, 32'h0,
                         1, 0, 7'h08, 32'h1111_1111, 0, 0, 0, hold_rd));
        for (int j = 0; j < 4; j++) add_c(32'h6000_0000 + 32'(j));
        add_d(32'h6000_00FF);

        foreach (tbl[i]) begin
            @(negedge clk);
            drv(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
                tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd, tbl[i].mrd);
            #1;
            chk($sformatf("v%0d_re", i), 32'(mem_re), 32'(tbl[i].xre));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].xwe));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].xaddr));
            chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].xwd);
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].xstall));
            chk($sformatf("v%0d_gnt", i), 32'(dma_gnt), 32'(tbl[i].xgnt));
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].mrd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].xrv));
            chk($sformatf("v%0d_rdata", i), dma_rdata, tbl[i].xrd);
        end

        // Reset pulsed during a forced DMA read slot
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            contended();
            #1;
            chk($sformatf("pre_rst_c%0d_gnt", j), 32'(dma_gnt), 0);
            @(posedge clk);
        end
        @(negedge clk);
        contended();
        #1;
        chk("force_gnt", 32'(dma_gnt), 1);
        chk("force_stall", 32'(cpu_stall), 1);
        #1 rst = 1'b1;
        #1;
        chk("in_rst_gnt", 32'(dma_gnt), 0);
        chk("in_rst_stall", 32'(cpu_stall), 0);
        chk("in_rst_addr", 32'(mem_addr), 32'h08);
        chk("in_rst_rdata", dma_rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rvalid", 32'(dma_rvalid), 0);
        chk("post_rst_rdata", dma_rdata, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            contended();
            #1;
            chk($sformatf("post_rst_c%0d_gnt", j), 32'(dma_gnt), (j == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
        end

        // Misaligned CPU load
        @(negedge clk);
        drv(1, 0, 32'h06, 0, 0, 0, 0, 0, 32'h0);
        #1;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        chk("mis_re", 32'(mem_re), 0);
        chk("mis_we", 32'(mem_we), 0);
        @(posedge clk);
        #1;
        chk("mis_err", 32'(err), 1);
        @(negedge clk);
        drv(0, 0, 0, 0, 1, 0, 7'h21, 0, 32'h9999_9999);
        #1;
        chk("mis_dma_gnt", 32'(dma_gnt), 1);
        chk("mis_dma_re", 32'(mem_re), 0);
        @(posedge clk);
        #1;
        chk("mis_dma_rvalid", 32'(dma_rvalid), 0);
        chk("mis_err_sticky", 32'(err), 1);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mis_err_cleared", 32'(err), 0);
        rst = 1'b0;
`else
        chk("mis_re", 32'(mem_re), 1);
        chk("mis_addr", 32'(mem_addr), 32'h06);
        @(posedge clk);
        #1;
        chk("mis_err", 32'(err), 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
